// File: rtl/branch_pkg.sv
// Shared encodings for the branch sequencer: request opcodes, FSM states, reset PC.
package branch_pkg;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_JMP  = 2'b01;
  localparam logic [1:0] OP_JLT  = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPARE = 2'd1,
    ST_UPDATE  = 2'd2
  } state_e;

  localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

endpackage

// File: rtl/serial_lt_cmp.sv
// Bit-serial MSB-first less-than comparator with early termination.
// signed_mode_i makes only the MSB decision two's-complement.
module serial_lt_cmp
  import branch_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              signed_mode_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              done_o,
  output logic              lt_o
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [IDX_W-1:0] idx_q;
  logic             run_q;
  logic             a_bit;
  logic             b_bit;
  logic             at_msb;
  logic             differ;
  logic             lt_bit;

  always_comb begin
    a_bit  = a_i[idx_q];
    b_bit  = b_i[idx_q];
    at_msb = (idx_q == IDX_W'(DATA_W - 1));
    differ = a_bit ^ b_bit;
    // In signed mode a set sign bit marks the smaller operand.
    lt_bit = (signed_mode_i && at_msb) ? (a_bit & ~b_bit) : (~a_bit & b_bit);
    done_o = run_q & (differ | (idx_q == '0));
    lt_o   = run_q & differ & lt_bit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      run_q <= 1'b0;
    end else if (start_i) begin
      idx_q <= IDX_W'(DATA_W - 1);
      run_q <= 1'b1;
    end else if (run_q) begin
      if (done_o) run_q <= 1'b0;
      else        idx_q <= idx_q - IDX_W'(1);
    end
  end

endmodule

// File: rtl/branch_sequencer.sv
// Program counter owner and JMP/JLT sequencer between decoder and fetch.
// Build option BRANCH_SIGNED_EN selects a signed JLT compare (default unsigned).
module branch_sequencer
  import branch_pkg::*;
#(
  parameter int              DATA_W   = 16,
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEFAULT_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [DATA_W-1:0] cmp_a,
  input  logic [DATA_W-1:0] cmp_b,
  input  logic [PC_W-1:0]   offset,
  input  logic              pc_advance,
  output logic [PC_W-1:0]   pc_out,
  output logic              busy,
  output logic              done_valid,
  output logic              taken
);

`ifdef BRANCH_SIGNED_EN
  localparam logic SIGNED_MODE = 1'b1;
`else
  localparam logic SIGNED_MODE = 1'b0;
`endif

  state_e            state_q;
  logic [PC_W-1:0]   pc_q;
  logic [PC_W-1:0]   pc_inc_d;
  logic [PC_W-1:0]   pc_jmp_d;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [PC_W-1:0]   off_q;
  logic [1:0]        op_q;
  logic              done_q;
  logic              taken_q;
  logic              handshake;
  logic              cmp_start;
  logic              cmp_done;
  logic              cmp_lt;

  always_comb begin
    handshake = req_valid & (state_q == ST_IDLE);
    cmp_start = handshake & (req_op == OP_JLT);
    pc_inc_d  = pc_q + PC_W'(1);
    pc_jmp_d  = pc_q + off_q;
  end

  serial_lt_cmp #(.DATA_W(DATA_W)) u_cmp (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_i       (cmp_start),
    .signed_mode_i (SIGNED_MODE),
    .a_i           (a_q),
    .b_i           (b_q),
    .done_o        (cmp_done),
    .lt_o          (cmp_lt)
  );

  // done/taken are registered on entry to UPDATE so they line up with that state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      a_q     <= '0;
      b_q     <= '0;
      off_q   <= '0;
      op_q    <= OP_NOP;
      done_q  <= 1'b0;
      taken_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (handshake) begin
            a_q   <= cmp_a;
            b_q   <= cmp_b;
            off_q <= offset;
            op_q  <= req_op;
            if (req_op == OP_JLT) begin
              state_q <= ST_COMPARE;
            end else begin
              state_q <= ST_UPDATE;
              done_q  <= 1'b1;
              taken_q <= (req_op == OP_JMP);
            end
          end else if (pc_advance) begin
            pc_q <= pc_inc_d;
          end
        end
        ST_COMPARE: begin
          if (cmp_done) begin
            state_q <= ST_UPDATE;
            done_q  <= 1'b1;
            taken_q <= cmp_lt;
          end
        end
        ST_UPDATE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          taken_q <= 1'b0;
          if (taken_q)             pc_q <= pc_jmp_d;
          else if (op_q != OP_RSVD) pc_q <= pc_inc_d;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign pc_out     = pc_q;
  assign done_valid = done_q;
  assign taken      = taken_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// Self-checking bench for branch_sequencer: scoreboard of expected retire results.
module tb_branch_sequencer;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [15:0] cmp_a;
  logic [15:0] cmp_b;
  logic [15:0] offset;
  logic        pc_advance;
  logic [15:0] pc_out;
  logic        busy;
  logic        done_valid;
  logic        taken;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        tk;
    logic [15:0] pc;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] model_pc;

  branch_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .cmp_a      (cmp_a),
    .cmp_b      (cmp_b),
    .offset     (offset),
    .pc_advance (pc_advance),
    .pc_out     (pc_out),
    .busy       (busy),
    .done_valid (done_valid),
    .taken      (taken)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic exp_t model(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                                 input logic [15:0] off, input logic [15:0] pc);
    exp_t e;
    logic lt;
    int   k;
`ifdef BRANCH_SIGNED_EN
    lt = ($signed(a) < $signed(b));
`else
    lt = (a < b);
`endif
    k = 16;
    for (int i = 15; i >= 0; i--) begin
      if (a[i] !== b[i]) begin
        k = 16 - i;
        break;
      end
    end
    case (op)
      2'b01:   begin e.tk = 1'b1; e.pc = pc + off; e.lat = 1; end
      2'b10:   begin e.tk = lt; e.pc = lt ? pc + off : pc + 16'd1; e.lat = 1 + k; end
      2'b11:   begin e.tk = 1'b0; e.pc = pc; e.lat = 1; end
      default: begin e.tk = 1'b0; e.pc = pc + 16'd1; e.lat = 1; end
    endcase
    return e;
  endfunction

  // Handshake edge is the posedge inside this task; inputs are scrambled right after it.
  task automatic issue(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] off, input logic adv);
    sb.push_back(model(op, a, b, off, model_pc));
    @(negedge clk);
    req_valid  = 1'b1;
    req_op     = op;
    cmp_a      = a;
    cmp_b      = b;
    offset     = off;
    pc_advance = adv;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    pc_advance = 1'b0;
    req_op     = 2'($urandom);
    cmp_a      = 16'($urandom);
    cmp_b      = 16'($urandom);
    offset     = 16'($urandom);
  endtask

  task automatic retire(output int lat, output logic tk, output logic [15:0] pc_after, output bit to);
    lat = 0; tk = 1'bx; pc_after = 16'hxxxx; to = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done_valid === 1'b1) begin
        lat = c; tk = taken; to = 1'b0;
        break;
      end
    end
    if (!to) begin
      @(negedge clk);
      pc_after = pc_out;
    end
  endtask

  task automatic advance_once();
    @(negedge clk);
    pc_advance = 1'b1;
    @(posedge clk);
    #1;
    pc_advance = 1'b0;
    model_pc = model_pc + 16'd1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++; if (pc_out !== 16'h0000) begin n_fail++; $display("FAIL reset pc_out: got %h expected 0000", pc_out); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b expected 0", busy); end
    n_checks++; if (done_valid !== 1'b0) begin n_fail++; $display("FAIL reset done_valid: got %b expected 0", done_valid); end
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset req_ready: got %b expected 1", req_ready); end
  endtask

  task automatic test_advance_to_0x10();
    for (int i = 0; i < 16; i++) advance_once();
    @(negedge clk);
    n_checks++; if (pc_out !== model_pc) begin n_fail++; $display("FAIL advance pc_out: got %h expected %h", pc_out, model_pc); end
  endtask

  task automatic run_table(input string nm, input logic [1:0] ops[], input logic [15:0] as[],
                           input logic [15:0] bs[], input logic [15:0] offs[]);
    exp_t e; int lat; logic tk; logic [15:0] pa; bit to;
    for (int i = 0; i < ops.size(); i++) begin
      issue(ops[i], as[i], bs[i], offs[i], 1'b0);
      retire(lat, tk, pa, to);
      e = sb.pop_front();
      if (to) begin
        n_checks++; n_fail++; $display("FAIL %s[%0d] timeout: no done_valid within 40 cycles", nm, i);
      end else begin
        n_checks++; if (lat !== e.lat) begin n_fail++; $display("FAIL %s[%0d] latency: got %0d expected %0d", nm, i, lat, e.lat); end
        n_checks++; if (tk !== e.tk) begin n_fail++; $display("FAIL %s[%0d] taken: got %b expected %b", nm, i, tk, e.tk); end
        n_checks++; if (pa !== e.pc) begin n_fail++; $display("FAIL %s[%0d] pc_out: got %h expected %h", nm, i, pa, e.pc); end
      end
      model_pc = e.pc;
    end
  endtask

  task automatic test_jmp();
    // 0x10 +5 -> 0x15, then back to 0x0001, then 0x0001 + 0xFFFE -> 0xFFFF
    run_table("jmp", '{2'b01, 2'b01, 2'b01}, '{16'h0, 16'h0, 16'h0}, '{16'h0, 16'h0, 16'h0},
              '{16'h0005, 16'hFFEC, 16'hFFFE});
    n_checks++; if (model_pc !== 16'hFFFF) begin n_fail++; $display("FAIL jmp chain end: got %h expected ffff", model_pc); end
  endtask

  task automatic test_advance_wrap();
    advance_once();
    @(negedge clk);
    n_checks++; if (pc_out !== 16'h0000) begin n_fail++; $display("FAIL advance wrap: got %h expected 0000", pc_out); end
  endtask

  task automatic test_jlt();
    run_table("jlt", '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10},
              '{16'h0000, 16'h8000, 16'h1234, 16'h0002, 16'h7FFF},
              '{16'h8000, 16'h0000, 16'h1234, 16'h0003, 16'h7F00},
              '{16'h0020, 16'h0100, 16'h0300, 16'h0008, 16'h0040});
  endtask

  task automatic test_nop_reserved();
    run_table("nop_rsvd", '{2'b00, 2'b11, 2'b11}, '{16'h0001, 16'hFFFF, 16'h0000},
              '{16'h0002, 16'h0000, 16'hFFFF}, '{16'h1111, 16'h2222, 16'hFFFF});
  endtask

  task automatic test_collisions();
    exp_t e; int lat; logic tk; logic [15:0] pa; bit to; logic [15:0] held;
    issue(2'b01, 16'h0, 16'h0, 16'h0003, 1'b1);
    retire(lat, tk, pa, to);
    e = sb.pop_front();
    n_checks++; if (to || pa !== e.pc) begin n_fail++; $display("FAIL collide same-cycle pc: got %h expected %h", pa, e.pc); end
    model_pc = e.pc;
    issue(2'b10, 16'h0002, 16'h0003, 16'h0010, 1'b1);
    pc_advance = 1'b1;
    held = model_pc;
    e = sb.pop_front();
    to = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      n_checks++; if (pc_out !== held) begin n_fail++; $display("FAIL collide busy pc c%0d: got %h expected %h", c, pc_out, held); end
      if (done_valid === 1'b1) begin
        to = 1'b0;
        n_checks++; if (c !== e.lat) begin n_fail++; $display("FAIL collide latency: got %0d expected %0d", c, e.lat); end
        n_checks++; if (taken !== e.tk) begin n_fail++; $display("FAIL collide taken: got %b expected %b", taken, e.tk); end
        break;
      end
    end
    if (to) begin n_checks++; n_fail++; $display("FAIL collide timeout: no done_valid within 40 cycles"); end
    @(negedge clk);
    pc_advance = 1'b0;
    n_checks++; if (pc_out !== e.pc) begin n_fail++; $display("FAIL collide final pc: got %h expected %h", pc_out, e.pc); end
    model_pc = e.pc;
  endtask

  task automatic test_reset_mid_jlt();
    exp_t e; int lat; logic tk; logic [15:0] pa; bit to;
    run_table("to_0x40", '{2'b01}, '{16'h0}, '{16'h0}, '{16'h0040 - model_pc});
    issue(2'b10, 16'hAAAA, 16'hAAAA, 16'h0004, 1'b0);
    void'(sb.pop_back());
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midjlt busy before reset: got %b expected 1", busy); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (pc_out !== 16'h0000) begin n_fail++; $display("FAIL midjlt pc_out: got %h expected 0000", pc_out); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midjlt busy: got %b expected 0", busy); end
    n_checks++; if (done_valid !== 1'b0) begin n_fail++; $display("FAIL midjlt done_valid: got %b expected 0", done_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    model_pc = 16'h0000;
    @(negedge clk);
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL midjlt req_ready: got %b expected 1", req_ready); end
    issue(2'b01, 16'h0, 16'h0, 16'h0007, 1'b0);
    retire(lat, tk, pa, to);
    e = sb.pop_front();
    n_checks++; if (to || lat !== 1 || pa !== e.pc) begin n_fail++; $display("FAIL post-reset jmp: lat %0d pc %h expected lat 1 pc %h", lat, pa, e.pc); end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_op = 2'b00;
    cmp_a = '0; cmp_b = '0; offset = '0; pc_advance = 1'b0;
    model_pc = 16'h0000;
    #22 rst_n = 1'b1;
    test_reset();
    test_advance_to_0x10();
    test_jmp();
    test_advance_wrap();
    test_jlt();
    test_nop_reserved();
    test_collisions();
    test_reset_mid_jlt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_sequencer.md
Name: branch_sequencer

Overview:
- Owns the 16-bit program counter and sequences the CPU's jump datapath.
- Accepts unconditional jump (JMP) and jump-if-less-than (JLT) requests from the decoder over a valid/ready handshake.
- JLT uses a bit-serial MSB-first compare with early termination, then applies the PC update.
- Sits between the decoder and fetch. Fetch advances the PC through this block.

Parameters:
- DATA_W, 16, comparator operand width (JLT scan length).
- PC_W, 16, program counter width. Offset and PC arithmetic are modulo 2^PC_W.
- RESET_PC, 16'h0000, PC value on reset.

Ports:
- clk  in  1  system clock; single clock domain, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- req_valid  in  1  decoder presents a branch request.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_op  in  2  2'b00 NOP, 2'b01 JMP, 2'b10 JLT, 2'b11 reserved.
- cmp_a  in  DATA_W  JLT operand A.
- cmp_b  in  DATA_W  JLT operand B.
- offset  in  PC_W  two's-complement PC offset.
- pc_advance  in  1  fetch requests PC+1.
- pc_out  out  PC_W  current program counter (registered).
- busy  out  1  high in COMPARE or UPDATE.
- done_valid  out  1  one-cycle pulse when a request retires.
- taken  out  1  valid with done_valid; 1 = PC loaded with pc+offset.

Behaviour:
- Reset (async, any state, mid-compare included):
  - state=IDLE, pc_out=RESET_PC, done_valid=0, taken=0, busy=0, req_ready=1 after release.
  - Latched operands are discarded.
- States: IDLE, COMPARE, UPDATE.
- IDLE:
  - req_ready=1.
  - Handshake fires on req_valid & req_ready. At that edge cmp_a, cmp_b, offset and req_op are latched; later input changes are ignored.
  - JMP, NOP, reserved → UPDATE.
  - JLT → COMPARE with bit index = DATA_W-1.
  - If pc_advance is high with no handshake, pc_out <= pc_out+1 (wraps 16'hFFFF → 16'h0000).
  - Handshake and pc_advance in the same cycle: handshake wins, advance dropped.
- COMPARE (one bit per cycle, MSB first):
  - a[i]=0, b[i]=1 → lt=1, go to UPDATE.
  - a[i]=1, b[i]=0 → lt=0, go to UPDATE.
  - Bits equal and i>0 → i-1, stay in COMPARE.
  - Bits equal at i=0 → lt=0 (A==B), go to UPDATE.
  - pc_advance is ignored.
- UPDATE (exactly one cycle):
  - done_valid=1.
  - taken=1 for JMP and for JLT with lt; 0 otherwise.
  - At the closing edge:
    - taken: pc_out <= pc_out + offset (modulo 2^PC_W; a negative offset wraps through 0).
    - JLT not taken or NOP: pc_out <= pc_out+1.
    - reserved: pc_out unchanged.
  - Next state IDLE; pc_advance ignored.
- Latency (handshake edge at T):
  - JMP/NOP: done_valid during cycle T+1, new PC visible T+2.
  - JLT deciding at bit i: k=DATA_W-i compare cycles. done_valid at T+1+k, new PC at T+2+k. Worst case (A==B): done at T+17.
- busy = (state != IDLE). No back-to-back acceptance: req_ready returns in the cycle after UPDATE.

Optional Feature:
- Macro BRANCH_SIGNED_EN.
- Defined: JLT is a two's-complement signed compare. At i=DATA_W-1 only, a=1,b=0 → lt=1 and a=0,b=1 → lt=0. Lower bits are unsigned as above.
- Undefined: JLT is a pure unsigned compare.
- All other behaviour and latency are identical in both builds.

Decomposition:
- Package branch_pkg holds:
  - op encoding constants (OP_NOP, OP_JMP, OP_JLT, OP_RSVD);
  - state enum (ST_IDLE, ST_COMPARE, ST_UPDATE);
  - default RESET_PC.
- One sub-module, serial_lt_cmp:
  - Inputs: start, operands, and a signed-mode bit tied by the macro.
  - Outputs: done, lt, with early termination.
- The top holds the FSM, PC register and handshake.

Test Plan:
- Reset mid-JLT: assert rst_n=0 during COMPARE at pc_out=16'h0040 → pc_out=16'h0000, busy=0, done_valid=0 immediately; req_ready=1 after release.
- JMP: pc_out=16'h0010, offset=16'h0005 → done_valid at T+1, taken=1; pc_out=16'h0015 at T+2. Repeat with offset=16'hFFFE from 16'h0001 → 16'hFFFF.
- JLT early-out: A=16'h0000, B=16'h8000 → done at T+2, taken=1. A=16'h8000, B=16'h0000 → done at T+2, taken=0, pc+1 (with BRANCH_SIGNED_EN: taken inverted in both cases).
- JLT full scan: A=B=16'h1234 → done at T+17, taken=0, pc+1. A=16'h0002, B=16'h0003 → done at T+17, taken=1.
- pc_advance collisions: advance with handshake in the same cycle → advance dropped. Advance held high through busy → no PC change until back in IDLE. Advance at 16'hFFFF → 16'h0000.
- Reserved op 2'b11: done_valid at T+1, taken=0, pc_out unchanged. Input changes after the handshake have no effect on the result.
